// File: rtl/axil_pkg.sv
// Shared AXI4-lite definitions for the register-file slave.
// Contents:
//   axil_resp_t        2-bit BRESP/RRESP encoding
//   AXIL_RESP_*        response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   axil_byte_merge()  per-byte write-strobe merge helper
package axil_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t AXIL_RESP_OKAY   = 2'b00;
  localparam axil_resp_t AXIL_RESP_EXOKAY = 2'b01;
  localparam axil_resp_t AXIL_RESP_SLVERR = 2'b10;
  localparam axil_resp_t AXIL_RESP_DECERR = 2'b11;

  // Selects the new byte when its strobe is set, otherwise keeps the old one.
  function automatic logic [7:0] axil_byte_merge(input logic [7:0] old_byte,
                                                 input logic [7:0] new_byte,
                                                 input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/axil_hold_reg.sv
// One-entry valid/ready holding buffer for a single AXI4-lite channel.
// The ready output is registered and equals "buffer empty next cycle", so an
// accepted beat blocks re-accept for at least one cycle.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_data/in_valid   upstream payload and valid
//   in_ready           registered ready (0 during reset, 1 once empty)
//   out_data/out_valid held payload and "entry occupied"
//   out_pop            consumer frees the entry this cycle
module axil_hold_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_pop
);

  logic held_d;
  logic accept;

  assign accept = in_valid & in_ready;

  // in_ready is only ever high while empty, so accept and pop never coincide.
  always_comb begin
    held_d = (out_valid & ~out_pop) | accept;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= held_d;
      in_ready  <= ~held_d;
      if (accept) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/axil_regfile_slave.sv
// AXI4-lite slave endpoint holding REG_COUNT DATA_WIDTH-bit control registers,
// exported in parallel to fabric logic. Read and write paths are independent,
// each with one transaction in flight.
// Build option: define AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses
// with SLVERR; otherwise they answer OKAY (data effects are identical).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   s_axil_aw*/w*/b*          AXI4-lite write address, data, response
//   s_axil_ar*/r*             AXI4-lite read address, data
//   reg_q                     register i at [i*DATA_WIDTH +: DATA_WIDTH]
//   reg_wr                    one-cycle pulse per register written (any strobe)
module axil_regfile_slave
  import axil_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
  parameter int unsigned REG_COUNT  = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDR_WIDTH-1:0]           s_axil_awaddr,
  input  logic [2:0]                      s_axil_awprot,
  input  logic                            s_axil_awvalid,
  output logic                            s_axil_awready,
  input  logic [DATA_WIDTH-1:0]           s_axil_wdata,
  input  logic [STRB_WIDTH-1:0]           s_axil_wstrb,
  input  logic                            s_axil_wvalid,
  output logic                            s_axil_wready,
  output logic [1:0]                      s_axil_bresp,
  output logic                            s_axil_bvalid,
  input  logic                            s_axil_bready,
  input  logic [ADDR_WIDTH-1:0]           s_axil_araddr,
  input  logic [2:0]                      s_axil_arprot,
  input  logic                            s_axil_arvalid,
  output logic                            s_axil_arready,
  output logic [DATA_WIDTH-1:0]           s_axil_rdata,
  output logic [1:0]                      s_axil_rresp,
  output logic                            s_axil_rvalid,
  input  logic                            s_axil_rready,
  output logic [REG_COUNT*DATA_WIDTH-1:0] reg_q,
  output logic [REG_COUNT-1:0]            reg_wr
);

  localparam int unsigned ADDR_LSB = $clog2(STRB_WIDTH);
  localparam int unsigned IDX_W    = ADDR_WIDTH - ADDR_LSB;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam axil_resp_t OOR_RESP = AXIL_RESP_SLVERR;
`else
  localparam axil_resp_t OOR_RESP = AXIL_RESP_OKAY;
`endif

  // Channel holds
  logic [ADDR_WIDTH-1:0]            aw_addr;
  logic [ADDR_WIDTH-1:0]            ar_addr;
  logic [STRB_WIDTH+DATA_WIDTH-1:0] w_payload;
  logic [DATA_WIDTH-1:0]            w_data;
  logic [STRB_WIDTH-1:0]            w_strb;
  logic                             aw_held;
  logic                             w_held;
  logic                             ar_held;
  logic                             wr_commit;
  logic                             rd_issue;

  axil_hold_reg #(
    .WIDTH(ADDR_WIDTH)
  ) u_aw_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_axil_awaddr),
    .in_valid (s_axil_awvalid),
    .in_ready (s_axil_awready),
    .out_data (aw_addr),
    .out_valid(aw_held),
    .out_pop  (wr_commit)
  );

  axil_hold_reg #(
    .WIDTH(STRB_WIDTH + DATA_WIDTH)
  ) u_w_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  ({s_axil_wstrb, s_axil_wdata}),
    .in_valid (s_axil_wvalid),
    .in_ready (s_axil_wready),
    .out_data (w_payload),
    .out_valid(w_held),
    .out_pop  (wr_commit)
  );

  axil_hold_reg #(
    .WIDTH(ADDR_WIDTH)
  ) u_ar_hold (
    .clk      (clk),
    .rst      (rst),
    .in_data  (s_axil_araddr),
    .in_valid (s_axil_arvalid),
    .in_ready (s_axil_arready),
    .out_data (ar_addr),
    .out_valid(ar_held),
    .out_pop  (rd_issue)
  );

  assign {w_strb, w_data} = w_payload;

  // A commit may coincide with the B handshake of the previous write.
  assign wr_commit = aw_held & w_held & (~s_axil_bvalid | s_axil_bready);
  assign rd_issue  = ar_held & (~s_axil_rvalid | s_axil_rready);

  // Decode: byte-lane address bits are ignored.
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             aw_in_range;
  logic             ar_in_range;

  assign aw_idx = aw_addr[ADDR_WIDTH-1:ADDR_LSB];
  assign ar_idx = ar_addr[ADDR_WIDTH-1:ADDR_LSB];

  // Extra bit keeps the compare correct when REG_COUNT == 2**IDX_W.
  assign aw_in_range = {1'b0, aw_idx} < (IDX_W + 1)'(REG_COUNT);
  assign ar_in_range = {1'b0, ar_idx} < (IDX_W + 1)'(REG_COUNT);

  // Register array
  logic [DATA_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0]  wr_hit;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      wr_hit[i] = wr_commit && (aw_idx == IDX_W'(i));
    end
  end

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = regs[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs[i] <= '0;
      end
      reg_wr <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) begin
        reg_wr[i] <= wr_hit[i] & (|w_strb);
        if (wr_hit[i]) begin
          for (int b = 0; b < STRB_WIDTH; b++) begin
            regs[i][b*8 +: 8] <= axil_byte_merge(regs[i][b*8 +: 8], w_data[b*8 +: 8],
                                                 w_strb[b]);
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_export
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

  // Write response channel
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_bvalid <= 1'b0;
      s_axil_bresp  <= AXIL_RESP_OKAY;
    end else if (wr_commit) begin
      s_axil_bvalid <= 1'b1;
      s_axil_bresp  <= aw_in_range ? AXIL_RESP_OKAY : OOR_RESP;
    end else if (s_axil_bready) begin
      s_axil_bvalid <= 1'b0;
    end
  end

  // Read data channel; rdata samples the array before any same-cycle write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_axil_rvalid <= 1'b0;
      s_axil_rresp  <= AXIL_RESP_OKAY;
      s_axil_rdata  <= '0;
    end else if (rd_issue) begin
      s_axil_rvalid <= 1'b1;
      s_axil_rresp  <= ar_in_range ? AXIL_RESP_OKAY : OOR_RESP;
      s_axil_rdata  <= rd_word;
    end else if (s_axil_rready) begin
      s_axil_rvalid <= 1'b0;
    end
  end

  // Protection bits and byte-lane address bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{s_axil_awprot, s_axil_arprot, aw_addr, ar_addr};

endmodule

// File: tb/tb_axil_regfile_slave.sv
// Directed self-checking bench for axil_regfile_slave (default parameters).
module tb_axil_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 16;
  localparam int SW = 4;
  localparam int RC = 16;

`ifdef AXIL_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [AW-1:0]  awaddr = '0;
  logic [2:0]     awprot = '0;
  logic           awvalid = 1'b0;
  logic           awready;
  logic [DW-1:0]  wdata = '0;
  logic [SW-1:0]  wstrb = '0;
  logic           wvalid = 1'b0;
  logic           wready;
  logic [1:0]     bresp;
  logic           bvalid;
  logic           bready = 1'b1;
  logic [AW-1:0]  araddr = '0;
  logic [2:0]     arprot = '0;
  logic           arvalid = 1'b0;
  logic           arready;
  logic [DW-1:0]  rdata;
  logic [1:0]     rresp;
  logic           rvalid;
  logic           rready = 1'b1;
  logic [RC*DW-1:0] reg_q;
  logic [RC-1:0]  reg_wr;

  int asserts = 0;
  int failures = 0;
  int wr_pulses = 0;

  always #5 clk = ~clk;

  axil_regfile_slave dut (
    .clk           (clk),
    .rst           (rst),
    .s_axil_awaddr (awaddr),
    .s_axil_awprot (awprot),
    .s_axil_awvalid(awvalid),
    .s_axil_awready(awready),
    .s_axil_wdata  (wdata),
    .s_axil_wstrb  (wstrb),
    .s_axil_wvalid (wvalid),
    .s_axil_wready (wready),
    .s_axil_bresp  (bresp),
    .s_axil_bvalid (bvalid),
    .s_axil_bready (bready),
    .s_axil_araddr (araddr),
    .s_axil_arprot (arprot),
    .s_axil_arvalid(arvalid),
    .s_axil_arready(arready),
    .s_axil_rdata  (rdata),
    .s_axil_rresp  (rresp),
    .s_axil_rvalid (rvalid),
    .s_axil_rready (rready),
    .reg_q         (reg_q),
    .reg_wr        (reg_wr)
  );

  always @(negedge clk) begin
    if (!rst && reg_wr != '0) wr_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  // Drives one write and waits for its B handshake. Call away from a posedge.
  task automatic axi_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s, output logic [1:0] resp,
                           output logic got);
    logic aw_f, w_f, b_f;
    logic [1:0] r;
    awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
    got = 1'b0; resp = 2'bxx;
    for (int n = 0; n < 40 && !got; n++) begin
      aw_f = awvalid & awready;
      w_f  = wvalid & wready;
      b_f  = bvalid & bready;
      r    = bresp;
      @(posedge clk); #1;
      if (aw_f) awvalid = 1'b0;
      if (w_f) wvalid = 1'b0;
      if (b_f) begin resp = r; got = 1'b1; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                          output logic [1:0] resp, output logic got);
    logic ar_f, r_f;
    logic [DW-1:0] dd;
    logic [1:0] rr;
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    got = 1'b0; resp = 2'bxx; d = 'x;
    for (int n = 0; n < 40 && !got; n++) begin
      ar_f = arvalid & arready;
      r_f  = rvalid & rready;
      dd   = rdata;
      rr   = rresp;
      @(posedge clk); #1;
      if (ar_f) arvalid = 1'b0;
      if (r_f) begin d = dd; resp = rr; got = 1'b1; end
    end
    arvalid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    asserts++; if (awready !== 1'b0) begin failures++; $display("FAIL rst_awready: got %b want 0", awready); end
    asserts++; if (wready !== 1'b0) begin failures++; $display("FAIL rst_wready: got %b want 0", wready); end
    asserts++; if (arready !== 1'b0) begin failures++; $display("FAIL rst_arready: got %b want 0", arready); end
    asserts++; if (bvalid !== 1'b0 || rvalid !== 1'b0) begin failures++; $display("FAIL rst_valids: got b=%b r=%b want 0 0", bvalid, rvalid); end
    asserts++; if (reg_q !== '0 || reg_wr !== '0) begin failures++; $display("FAIL rst_regs: got nonzero reg_q/reg_wr want 0"); end
    asserts++; if (rdata !== '0 || bresp !== 2'b00 || rresp !== 2'b00) begin failures++; $display("FAIL rst_data: got rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp); end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    asserts++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL post_rst_ready: got %b want 111", {awready, wready, arready}); end
  endtask

  task automatic test_first_read();
    araddr = 16'h0000; arvalid = 1'b1; rready = 1'b1;   // cycle 0
    @(negedge clk); arvalid = 1'b0;                     // cycle 1
    asserts++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_lat_c1: got rvalid=%b want 0", rvalid); end
    @(negedge clk);                                     // cycle 2
    asserts++; if (rvalid !== 1'b1) begin failures++; $display("FAIL rd_lat_c2: got rvalid=%b want 1", rvalid); end
    asserts++; if (rdata !== 32'h0 || rresp !== 2'b00) begin failures++; $display("FAIL rd_first_data: got %h/%b want 0/00", rdata, rresp); end
    @(negedge clk);
    asserts++; if (rvalid !== 1'b0) begin failures++; $display("FAIL rd_drop: got rvalid=%b want 0", rvalid); end
  endtask

  task automatic test_write_latency();
    bready = 1'b1;
    awaddr = 16'h0004; awvalid = 1'b1;                  // cycle 0
    @(negedge clk); awvalid = 1'b0;                     // cycle 1
    asserts++; if (awready !== 1'b0) begin failures++; $display("FAIL aw_hold_full: got awready=%b want 0", awready); end
    @(negedge clk);                                     // cycle 2
    @(negedge clk);                                     // cycle 3
    wdata = 32'hDEADBEEF; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); wvalid = 1'b0;                      // cycle 4
    asserts++; if (bvalid !== 1'b0) begin failures++; $display("FAIL wr_lat_c4: got bvalid=%b want 0", bvalid); end
    @(negedge clk);                                     // cycle 5
    asserts++; if (bvalid !== 1'b1 || bresp !== 2'b00) begin failures++; $display("FAIL wr_lat_c5: got bvalid=%b bresp=%b want 1 00", bvalid, bresp); end
    asserts++; if (reg_wr !== 16'h0002) begin failures++; $display("FAIL wr_pulse: got %h want 0002", reg_wr); end
    asserts++; if (reg_q[63:32] !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_reg1: got %h want deadbeef", reg_q[63:32]); end
    @(negedge clk);                                     // cycle 6
    asserts++; if (bvalid !== 1'b0 || reg_wr !== '0) begin failures++; $display("FAIL wr_after: got bvalid=%b reg_wr=%h want 0 0", bvalid, reg_wr); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic got;
    int p0;
    p0 = wr_pulses;
    axi_write(16'h0004, 32'h000000AA, 4'h1, resp, got);
    asserts++; if (got !== 1'b1 || resp !== 2'b00) begin failures++; $display("FAIL strb1_resp: got got=%b resp=%b want 1 00", got, resp); end
    asserts++; if (reg_q[63:32] !== 32'hDEADBEAA) begin failures++; $display("FAIL strb1_data: got %h want deadbeaa", reg_q[63:32]); end
    asserts++; if (wr_pulses !== p0 + 1) begin failures++; $display("FAIL strb1_pulse: got %0d pulses want %0d", wr_pulses - p0, 1); end
    p0 = wr_pulses;
    axi_write(16'h0004, 32'h12345678, 4'h0, resp, got);
    @(negedge clk);
    asserts++; if (got !== 1'b1 || resp !== 2'b00) begin failures++; $display("FAIL strb0_resp: got got=%b resp=%b want 1 00", got, resp); end
    asserts++; if (reg_q[63:32] !== 32'hDEADBEAA) begin failures++; $display("FAIL strb0_data: got %h want deadbeaa", reg_q[63:32]); end
    asserts++; if (wr_pulses !== p0) begin failures++; $display("FAIL strb0_pulse: got %0d pulses want 0", wr_pulses - p0); end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bready = 1'b0;
    awaddr = 16'h0008; awvalid = 1'b1; wdata = 32'h11; wstrb = 4'hF; wvalid = 1'b1; // c0
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;                                  // c1
    @(negedge clk);                                                                 // c2
    asserts++; if (bvalid !== 1'b1 || awready !== 1'b1) begin failures++; $display("FAIL bp_first_b: got bvalid=%b awready=%b want 1 1", bvalid, awready); end
    awaddr = 16'h000C; awvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;                                  // c3
    for (int c = 3; c < 12; c++) begin
      asserts++;
      if (bvalid !== 1'b1 || bresp !== 2'b00 || awready !== 1'b0 || wready !== 1'b0) begin
        failures++;
        $display("FAIL bp_stall_c%0d: got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                 c, bvalid, bresp, awready, wready);
      end
      if (c < 11) @(negedge clk);
    end
    asserts++; if (reg_q[127:96] !== 32'h0 || reg_q[95:64] !== 32'h11) begin failures++; $display("FAIL bp_regs_stall: got r2=%h r3=%h want 11 0", reg_q[95:64], reg_q[127:96]); end
    @(negedge clk); bready = 1'b1;                                                  // c12
    @(negedge clk);                                                                 // c13
    asserts++; if (bvalid !== 1'b1 || reg_wr !== 16'h0008) begin failures++; $display("FAIL bp_second_b: got bvalid=%b reg_wr=%h want 1 0008", bvalid, reg_wr); end
    asserts++; if (reg_q[127:96] !== 32'h22) begin failures++; $display("FAIL bp_reg3: got %h want 22", reg_q[127:96]); end
    @(negedge clk);                                                                 // c14
    asserts++; if (bvalid !== 1'b0) begin failures++; $display("FAIL bp_done: got bvalid=%b want 0", bvalid); end
  endtask

  task automatic test_out_of_range();
    logic [1:0] resp;
    logic got;
    logic [DW-1:0] d;
    logic [RC*DW-1:0] exp_q;
    int p0;
    exp_q = '0;
    exp_q[32 +: 32] = 32'hDEADBEAA;
    exp_q[64 +: 32] = 32'h11;
    exp_q[96 +: 32] = 32'h22;
    p0 = wr_pulses;
    axi_write(16'h0040, 32'hFFFFFFFF, 4'hF, resp, got);
    @(negedge clk);
    asserts++; if (got !== 1'b1 || resp !== OOR_RESP) begin failures++; $display("FAIL oor_wr_resp: got %b want %b", resp, OOR_RESP); end
    asserts++; if (reg_q !== exp_q || wr_pulses !== p0) begin failures++; $display("FAIL oor_wr_effect: got pulses=%0d want 0, regs changed=%b", wr_pulses - p0, reg_q !== exp_q); end
    axi_read(16'h0040, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'h0 || resp !== OOR_RESP) begin failures++; $display("FAIL oor_rd: got %h/%b want 0/%b", d, resp, OOR_RESP); end
    axi_write(16'h003C, 32'h5A5A5A5A, 4'hF, resp, got);
    asserts++; if (got !== 1'b1 || resp !== 2'b00) begin failures++; $display("FAIL last_wr_resp: got %b want 00", resp); end
    axi_read(16'h003C, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'h5A5A5A5A || resp !== 2'b00) begin failures++; $display("FAIL last_rd: got %h/%b want 5a5a5a5a/00", d, resp); end
    axi_read(16'h0007, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'hDEADBEAA) begin failures++; $display("FAIL lowbits_rd: got %h want deadbeaa", d); end
  endtask

  task automatic test_same_cycle();
    logic [1:0] resp;
    logic got;
    logic [DW-1:0] d;
    axi_write(16'h0008, 32'h1, 4'hF, resp, got);
    @(negedge clk);
    asserts++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL same_ready: got %b want 111", {awready, wready, arready}); end
    awaddr = 16'h0008; awvalid = 1'b1; wdata = 32'h2; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 16'h0008; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;               // c0
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;                 // c1
    @(negedge clk);                                                                // c2
    asserts++; if (rvalid !== 1'b1 || rdata !== 32'h1) begin failures++; $display("FAIL same_old: got rvalid=%b rdata=%h want 1 1", rvalid, rdata); end
    asserts++; if (bvalid !== 1'b1 || reg_q[95:64] !== 32'h2) begin failures++; $display("FAIL same_wr: got bvalid=%b r2=%h want 1 2", bvalid, reg_q[95:64]); end
    @(negedge clk);
    axi_read(16'h0008, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'h2) begin failures++; $display("FAIL same_new: got %h want 2", d); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] resp;
    logic got;
    logic [DW-1:0] d;
    @(negedge clk);
    bready = 1'b0;
    awaddr = 16'h000C; awvalid = 1'b1; wdata = 32'h33; wstrb = 4'hF; wvalid = 1'b1; // c0
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0;                                  // c1
    @(negedge clk);                                                                 // c2
    asserts++; if (bvalid !== 1'b1) begin failures++; $display("FAIL mid_b_pending: got %b want 1", bvalid); end
    awaddr = 16'h0004; awvalid = 1'b1;
    @(negedge clk); awvalid = 1'b0;                                                 // c3
    asserts++; if (awready !== 1'b0) begin failures++; $display("FAIL mid_aw_held: got awready=%b want 0", awready); end
    rst = 1'b1;
    @(negedge clk);                                                                 // c4
    asserts++; if (bvalid !== 1'b0 || reg_q !== '0) begin failures++; $display("FAIL mid_rst_clear: got bvalid=%b regs_zero=%b want 0 1", bvalid, reg_q === '0); end
    rst = 1'b0; bready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    asserts++; if ({awready, wready, arready} !== 3'b111) begin failures++; $display("FAIL mid_ready: got %b want 111", {awready, wready, arready}); end
    axi_write(16'h0010, 32'h5, 4'hF, resp, got);
    asserts++; if (got !== 1'b1 || resp !== 2'b00) begin failures++; $display("FAIL mid_wr: got got=%b resp=%b want 1 00", got, resp); end
    axi_read(16'h0004, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'h0) begin failures++; $display("FAIL mid_stale_aw: got %h want 0", d); end
    axi_read(16'h0010, d, resp, got);
    asserts++; if (got !== 1'b1 || d !== 32'h5) begin failures++; $display("FAIL mid_rd: got %h want 5", d); end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_write_latency();
    test_strobe();
    test_back_to_back();
    test_out_of_range();
    test_same_cycle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
